prv32_alu_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle prv32 ALU. It keeps every base RV32I ALU operation and adds the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative radix-2 datapath. It sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on in_ready/out_valid instead of assuming a fixed latency. A flush input lets the hazard unit abort an in-flight M operation on a branch or trap.

---
 rtl/prv32_alu_pkg.sv | 34 +++
 rtl/prv32_muldiv_iter.sv | 116 +++++++++++
 rtl/prv32_alu_mc.sv | 143 ++++++++++++++
 tb/tb_prv32_alu_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/prv32_alu_pkg.sv
// Shared op codes and FSM state type for the multi-cycle prv32 ALU.
package prv32_alu_pkg;

   // Base ALU operations (op[4] = 0)
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   // M-extension operations (op[4] = 1, code in op[2:0]); op[2] marks divide,
   // op[1] within a divide selects the remainder.
   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/prv32_muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider. Works on operand
// magnitudes latched at start; the sign is restored on the final step, which
// is presented combinationally on result while done is high.
module prv32_muldiv_iter
   import prv32_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   logic            busy;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi, lo, m;
   logic [2:0]      opq;
   logic            neg_q, neg_r;

   logic            a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0] ma, mb;
   logic [XLEN-1:0] hi_n, lo_n;
   logic [XLEN:0]   sum, shl, diff;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] quo, rem;

   // Operand sign decode and magnitude conversion at start
   always_comb begin
      a_sgn = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
      b_sgn = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
      a_neg = a_sgn && a[XLEN-1];
      b_neg = b_sgn && b[XLEN-1];
      ma    = a_neg ? -a : a;
      mb    = b_neg ? -b : b;
   end

   // One shift-add (multiply) or restoring-subtract (divide) step.
   // hi:lo is the product accumulator, or remainder:quotient for divide.
   always_comb begin
      hi_n = hi;
      lo_n = lo;
      sum  = '0;
      shl  = '0;
      diff = '0;
      if (opq[2]) begin
         shl  = {hi, lo[XLEN-1]};
         diff = shl - {1'b0, m};
         if (!diff[XLEN]) begin
            hi_n = diff[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_n = shl[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo[XLEN-1:1]};
      end
   end

   // Sign fix-up and result select from the step output
   always_comb begin
      prod   = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      quo    = neg_q ? -lo_n : lo_n;
      rem    = neg_r ? -hi_n : hi_n;
      result = '0;
      case (opq)
         MD_MUL:                     result = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:            result = quo;
         default:                    result = rem;
      endcase
      done = busy && (cnt == '0);
   end

   // Iteration state: load on start, step while busy, stop on last step or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         m     <= '0;
         opq   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (flush) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= CW'(XLEN-1);
         opq   <= op;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         hi    <= '0;
         lo    <= op[2] ? ma : mb;
         m     <= op[2] ? mb : ma;
      end else if (busy) begin
         hi <= hi_n;
         lo <= lo_n;
         if (cnt == '0) busy <= 1'b0;
         else           cnt  <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/prv32_alu_mc.sv
// Multi-cycle prv32 ALU: single-cycle base ops plus iterative M extension,
// behind valid/ready handshakes on both sides with a synchronous flush.
module prv32_alu_mc
   import prv32_alu_pkg::*;
#(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [SHW-1:0]  shamt,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] r,
   output logic            cf,
   output logic            zf,
   output logic            vf,
   output logic            sf
);

   state_t state, state_n;

   logic            accept, md_start, md_done, early, is_sub;
   logic [XLEN-1:0] md_res, early_r, base_r, bb, add;
   logic            cf_n, zf_n, vf_n, sf_n;

   prv32_muldiv_iter #(.XLEN(XLEN)) u_md (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .start  (md_start),
      .op     (op[2:0]),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .result (md_res)
   );

   // Base datapath: shared adder drives the flags, SLT/SLTU and add/sub
   always_comb begin
      is_sub = (op[3:0] == ALU_SUB) || (op[3:0] == ALU_SLT) || (op[3:0] == ALU_SLTU);
      bb     = is_sub ? ~b : b;
      {cf_n, add} = {1'b0, a} + {1'b0, bb} + (XLEN+1)'(is_sub);
      vf_n   = a[XLEN-1] ^ bb[XLEN-1] ^ add[XLEN-1] ^ cf_n;
      sf_n   = add[XLEN-1];
      zf_n   = (add == '0);
      case (op[3:0])
         ALU_AND:  base_r = a & b;
         ALU_OR:   base_r = a | b;
         ALU_XOR:  base_r = a ^ b;
         ALU_SLL:  base_r = a << shamt;
         ALU_SRL:  base_r = a >> shamt;
         ALU_SRA:  base_r = $unsigned($signed(a) >>> shamt);
         ALU_SLT:  base_r = {{(XLEN-1){1'b0}}, sf_n != vf_n};
         ALU_SLTU: base_r = {{(XLEN-1){1'b0}}, ~cf_n};
         ALU_PASS: base_r = b;
         default:  base_r = add;
      endcase
   end

   // Divide corner cases resolved at accept: by zero, and MIN / -1 overflow
   always_comb begin
      early   = 1'b0;
      early_r = '0;
      if (op[4] && op[2]) begin
         if (b == '0) begin
            early   = 1'b1;
            early_r = op[1] ? a : '1;
         end else if (!op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
            early   = 1'b1;
            early_r = op[1] ? '0 : a;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // FSM next state; flush wins over everything else
   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: if (accept) state_n = md_start ? CALC : DONE;
            CALC: if (md_done) state_n = DONE;
            DONE: if (out_ready) state_n = accept ? (md_start ? CALC : DONE) : IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // FSM outputs and handshake decode
   always_comb begin
      out_valid = (state == DONE);
      in_ready  = rst_n && !flush &&
                  ((state == IDLE) || ((state == DONE) && out_ready));
      accept    = in_valid && in_ready;
      md_start  = accept && op[4] && !early;
   end

   // Result and flag registers; hold while no new result is produced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r  <= '0;
         cf <= 1'b0;
         zf <= 1'b0;
         vf <= 1'b0;
         sf <= 1'b0;
      end else if (!flush) begin
         if (accept && !op[4]) begin
            r  <= base_r;
            cf <= cf_n;
            zf <= zf_n;
            vf <= vf_n;
            sf <= sf_n;
         end else if (accept && early) begin
            r  <= early_r;
            cf <= 1'b0;
            zf <= (early_r == '0);
            vf <= 1'b0;
            sf <= 1'b0;
         end else if ((state == CALC) && md_done) begin
            r  <= md_res;
            cf <= 1'b0;
            zf <= (md_res == '0);
            vf <= 1'b0;
            sf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prv32_alu_mc.sv
// Scoreboard bench for prv32_alu_mc: the driver pushes expected results at
// accept, a negedge monitor pops and checks value, flags and latency.
module tb_prv32_alu_mc;
   import prv32_alu_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, cf, zf, vf, sf;
   logic [4:0]  op = '0, shamt = '0;
   logic [31:0] a = '0, b = '0, r;

   typedef struct {
      string       nm;
      logic [31:0] r;
      logic [3:0]  f;
      bit          chkf;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   int   total = 0, bad = 0, cyc = 0;
   bit   seen = 0;

   prv32_alu_mc #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .cf(cf), .zf(zf), .vf(vf), .sf(sf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] mf(logic [31:0] x);
      return {1'b0, x == 32'h0, 2'b00};
   endfunction

   // Monitor: one check per presented result
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (rst_n) begin
         if (out_valid && !seen) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: got r=%h with empty scoreboard", r);
            end else begin
               e = sbq.pop_front();
               chk({e.nm, "_r"}, r, e.r);
               chk({e.nm, "_lat"}, cyc - e.acc, e.lat);
               if (e.chkf) chk({e.nm, "_flags"}, {28'h0, cf, zf, vf, sf}, {28'h0, e.f});
            end
            seen = 1;
         end
         if (!out_valid || out_ready) seen = 0;
      end else begin
         seen = 0;
      end
   end

   // Drive one op; caller is just past a negedge. Returns after the accept edge.
   task automatic issue(string nm, logic [4:0] o, logic [31:0] aa, logic [31:0] bv,
                        logic [4:0] sh, logic [31:0] er, logic [3:0] ef, bit fchk,
                        int lat, bit push);
      exp_t e;
      op = o; a = aa; b = bv; shamt = sh; in_valid = 1'b1;
      #1;
      for (int i = 0; i < 100 && !in_ready; i++) begin
         @(negedge clk);
         #1;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL %s_accept: in_ready=0 want 1", nm);
      end else if (push) begin
         e.nm = nm; e.r = er; e.f = ef; e.chkf = fchk; e.lat = lat; e.acc = cyc;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 32'hDEADBEEF; b = 32'hDEADBEEF; op = {1'b0, ALU_XOR};
   endtask

   task automatic base(string nm, logic [3:0] o, logic [31:0] aa, logic [31:0] bv,
                       logic [4:0] sh, logic [31:0] er, logic [3:0] ef, bit fchk);
      @(negedge clk);
      issue(nm, {1'b0, o}, aa, bv, sh, er, ef, fchk, 1, 1);
   endtask

   task automatic md(string nm, logic [2:0] o, logic [31:0] aa, logic [31:0] bv,
                     logic [31:0] er, int lat);
      @(negedge clk);
      issue(nm, {2'b10, o}, aa, bv, 5'd0, er, mf(er), 1, lat, 1);
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #4;
         if (sbq.size() == 0 && !out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d want 0", sbq.size());
      end
   endtask

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_r", r, 32'h0);
      chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
      chk("rst_flags", {28'h0, cf, zf, vf, sf}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", {31'h0, in_ready}, 32'h1);

      // Base ops, back to back; flags are {cf,zf,vf,sf}
      base("add_ovf", ALU_ADD,  32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 4'b0011, 1);
      base("sub_zero", ALU_SUB, 32'h5, 32'h5, 5'd0, 32'h0, 4'b1100, 1);
      base("slt_neg", ALU_SLT,  32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 4'b1001, 1);
      base("sltu_big", ALU_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 4'b1001, 1);
      base("slt_pos", ALU_SLT,  32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 4'b0000, 1);
      base("sltu_sm", ALU_SLTU, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h1, 4'b0000, 1);
      base("and", ALU_AND, 32'hF0F01234, 32'h0FF0FF00, 5'd0, 32'h00F01200, 4'b0, 0);
      base("xor", ALU_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0, 32'hF0F00F0F, 4'b0, 0);
      base("sll31", ALU_SLL, 32'h1, 32'h0, 5'd31, 32'h80000000, 4'b0, 0);
      base("srl4", ALU_SRL, 32'h80000000, 32'h0, 5'd4, 32'h08000000, 4'b0, 0);
      base("sra4", ALU_SRA, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 4'b0, 0);
      base("pass", ALU_PASS, 32'h11111111, 32'h1234, 5'd0, 32'h1234, 4'b0, 0);

      // M ops: iterative (33) and early-out (1)
      md("mulh",    MD_MULH,   32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33);
      md("mulhu",   MD_MULHU,  32'hFFFFFFFF, 32'h2, 32'h00000001, 33);
      md("mul",     MD_MUL,    32'hFFFFFFFD, 32'h5, 32'hFFFFFFF1, 33);
      md("mulhsu1", MD_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33);
      md("mulhsu2", MD_MULHSU, 32'h2, 32'hFFFFFFFF, 32'h00000001, 33);
      md("div_ovf", MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      md("rem_ovf", MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
      md("divu_z",  MD_DIVU,   32'h5, 32'h0, 32'hFFFFFFFF, 1);
      md("remu_z",  MD_REMU,   32'h9, 32'h0, 32'h9, 1);
      md("div_z",   MD_DIV,    32'h3, 32'h0, 32'hFFFFFFFF, 1);
      md("rem_m7",  MD_REM,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
      md("div_m7",  MD_DIV,    32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
      md("divu",    MD_DIVU,   32'd100, 32'd7, 32'd14, 33);
      md("remu",    MD_REMU,   32'd100, 32'd7, 32'd2, 33);
      md("div_min", MD_DIV,    32'h80000000, 32'h2, 32'hC0000000, 33);
      drain();

      // Backpressure: result held for 5 cycles, then handoff with no bubble
      out_ready = 1'b0;
      md("mul_bp", MD_MUL, 32'd6, 32'd7, 32'd42, 33);
      n = 0;
      for (int i = 0; i < 60 && !out_valid; i++) begin
         @(negedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("bp_r", r, 32'd42);
         chk("bp_valid", {31'h0, out_valid}, 32'h1);
         chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      end
      out_ready = 1'b1;
      issue("sub_b2b", {1'b0, ALU_SUB}, 32'd3, 32'd5, 5'd0, 32'hFFFFFFFE, 4'b0001, 1, 1, 1);
      drain();

      // Flush in the middle of a DIVU, with a competing request that must be dropped
      @(negedge clk);
      issue("divu_fl", {2'b10, MD_DIVU}, 32'd100, 32'd7, 5'd0, 32'h0, 4'b0, 0, 0, 0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      in_valid = 1'b1;
      op = {1'b0, ALU_ADD}; a = 32'h1; b = 32'h1;
      #1;
      chk("fl_in_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("fl_idle_ready", {31'h0, in_ready}, 32'h1);
      chk("fl_r_kept", r, 32'hFFFFFFFE);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (out_valid) n++;
      end
      chk("fl_no_out", n, 0);

      // Async reset in the middle of a MUL
      @(negedge clk);
      issue("mul_rst", {2'b10, MD_MUL}, 32'd3, 32'd3, 5'd0, 32'h0, 4'b0, 0, 0, 0);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", {31'h0, out_valid}, 32'h0);
      chk("ar_r", r, 32'h0);
      chk("ar_in_ready", {31'h0, in_ready}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      base("add_post", ALU_ADD, 32'd2, 32'd2, 5'd0, 32'd4, 4'b0000, 1);
      md("div_post", MD_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
